// File: rtl/rx9_io80_pkg.sv
// Shared constants, state type and lane-slicing helper for the 9-lane
// 10-to-80 LVDS receive reassembly block.
package rx9_io80_pkg;

  localparam int NUM_LANES = 9;
  localparam int BEAT_W    = 10;
  localparam int BEATS     = 8;
  localparam int WORD_W    = 80;

  // Phase value on which the final beat of a word is present at the input.
  localparam logic [2:0] LAST_PH = 3'(BEATS - 1);

  // Training word the transmitter repeats on every lane while aligning.
  localparam logic [WORD_W-1:0] SYNC_WORD_DEF = 80'hBC5A3C96F00FA55AC3E1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HUNT    = 2'd1,
    CONFIRM = 2'd2,
    LOCKED  = 2'd3
  } state_e;

  // Extract one lane's 10-bit beat from the flat receiver bus.
  function automatic logic [BEAT_W-1:0] lane_beat(
    input logic [NUM_LANES*BEAT_W-1:0] rx,
    input int                          lane
  );
    return rx[lane*BEAT_W +: BEAT_W];
  endfunction

endpackage

// File: rtl/rx9_io80_demux_10_80.sv
// One lane of the receive path: an 8-beat shift register, a compare of the
// current 8-beat window against the training word, and an 80-bit output
// register loaded when the top level signals a word boundary.
module demux_10_80
  import rx9_io80_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [BEAT_W-1:0] beat_i,
  input  logic              cap_en_i,
  output logic              match_o,
  output logic [WORD_W-1:0] word_o
);

  logic [WORD_W-1:0] sr_q;
  logic [WORD_W-1:0] sr_d;
  logic [WORD_W-1:0] cap_q;
  logic [WORD_W-1:0] cap_d;

  // Window including this cycle's beat: newest beat enters at the top, so
  // after eight beats the first one of the word sits in bits [9:0].
  always_comb begin
    sr_d = {beat_i, sr_q[WORD_W-1:BEAT_W]};
  end

  // Shift register runs every cycle regardless of alignment state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= {WORD_W{1'b0}};
    end else begin
      sr_q <= sr_d;
    end
  end

  // Output word loads the completed window on a boundary, otherwise holds.
  always_comb begin
    if (cap_en_i) begin
      cap_d = sr_d;
    end else begin
      cap_d = cap_q;
    end
  end

  // Output word register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_q <= {WORD_W{1'b0}};
    end else begin
      cap_q <= cap_d;
    end
  end

  // Compare uses the window that ends with the beat present this cycle, so a
  // hit means the next beat starts a new word.
  assign match_o = (sr_d == SYNC_WORD);
  assign word_o  = cap_q;

endmodule

// File: rtl/rx9_io80.sv
// 9-lane receive reassembly: per-lane 10-to-80 demux plus the alignment
// FSM (hunt for the training word on all lanes, confirm it on consecutive
// word boundaries, then deliver one word per lane every 8 cycles).
module rx9_io80
  import rx9_io80_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_WORD   = SYNC_WORD_DEF,
  parameter int                CONFIRM_CNT = 4
) (
  input  logic                        I_clk,
  input  logic                        I_rst,
  input  logic                        I_rx_locked,
  input  logic                        I_realign,
  input  logic [NUM_LANES*BEAT_W-1:0] I_rx_in,
  output logic [WORD_W-1:0]           o0_p,
  output logic [WORD_W-1:0]           o1_p,
  output logic [WORD_W-1:0]           o2_p,
  output logic [WORD_W-1:0]           o3_p,
  output logic [WORD_W-1:0]           o4_p,
  output logic [WORD_W-1:0]           o5_p,
  output logic [WORD_W-1:0]           o6_p,
  output logic [WORD_W-1:0]           o7_p,
  output logic [WORD_W-1:0]           o8_p,
  output logic                        O_valid,
  output logic                        O_aligned,
  output logic                        O_skew_err
);

  localparam logic [3:0] CONFIRM_TGT = 4'(CONFIRM_CNT);

  state_e            state_q;
  state_e            state_d;
  logic [2:0]        ph_q;
  logic [2:0]        ph_d;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;
  logic              valid_q;
  logic              valid_d;
  logic              aligned_q;
  logic              aligned_d;
  logic              skew_q;
  logic              skew_d;
  logic              cap_en_s;
  logic              all_match_s;
  logic              any_match_s;
  logic [NUM_LANES-1:0] match_s;
  logic [WORD_W-1:0] word_s [NUM_LANES];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    demux_10_80 #(
      .SYNC_WORD (SYNC_WORD)
    ) u_demux (
      .clk_i    (I_clk),
      .rst_i    (I_rst),
      .beat_i   (lane_beat(I_rx_in, g)),
      .cap_en_i (cap_en_s),
      .match_o  (match_s[g]),
      .word_o   (word_s[g])
    );
  end

  assign all_match_s = &match_s;
  assign any_match_s = |match_s;

  // Next state, phase, confirm count, skew flag and capture strobe.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q + 3'd1;
    cnt_d    = cnt_q;
    skew_d   = skew_q;
    valid_d  = 1'b0;
    cap_en_s = 1'b0;
    if (!I_rx_locked) begin
      // Losing PLL lock overrides everything, including a pending capture.
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else if (I_realign && (state_q != IDLE)) begin
      // Realign wins over a same-cycle capture.
      state_d = HUNT;
      cnt_d   = 4'd0;
      skew_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = HUNT;
        end
        HUNT: begin
          if (all_match_s) begin
            // Next beat starts a word: restart the phase there.
            ph_d  = 3'd0;
            cnt_d = 4'd1;
            if (CONFIRM_TGT == 4'd1) begin
              state_d = LOCKED;
            end else begin
              state_d = CONFIRM;
            end
          end else if (any_match_s) begin
            skew_d = 1'b1;
          end else begin
            skew_d = skew_q;
          end
        end
        CONFIRM: begin
          if (ph_q == LAST_PH) begin
            if (all_match_s) begin
              cnt_d = cnt_q + 4'd1;
              if ((cnt_q + 4'd1) == CONFIRM_TGT) begin
                state_d = LOCKED;
              end else begin
                state_d = CONFIRM;
              end
            end else begin
              state_d = HUNT;
              cnt_d   = 4'd0;
            end
          end else begin
            state_d = CONFIRM;
          end
        end
        LOCKED: begin
          if (ph_q == LAST_PH) begin
            cap_en_s = 1'b1;
            valid_d  = 1'b1;
          end else begin
            cap_en_s = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
    aligned_d = (state_d == LOCKED);
  end

  // Control registers with synchronous reset.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q   <= IDLE;
      ph_q      <= 3'd0;
      cnt_q     <= 4'd0;
      valid_q   <= 1'b0;
      aligned_q <= 1'b0;
      skew_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      aligned_q <= aligned_d;
      skew_q    <= skew_d;
    end
  end

  assign o0_p       = word_s[0];
  assign o1_p       = word_s[1];
  assign o2_p       = word_s[2];
  assign o3_p       = word_s[3];
  assign o4_p       = word_s[4];
  assign o5_p       = word_s[5];
  assign o6_p       = word_s[6];
  assign o7_p       = word_s[7];
  assign o8_p       = word_s[8];
  assign O_valid    = valid_q;
  assign O_aligned  = aligned_q;
  assign O_skew_err = skew_q;

endmodule

// File: doc/rx9_io80.md
Name: rx9_io80

Overview:
Receive-side counterpart of the 9-lane 80-to-10 LVDS transmit path.
- Takes the 9x10-bit parallel output of the LVDS receiver core (one 10-bit beat per lane per core-clock cycle).
- Finds the 8-beat word boundary using a training sync word and reassembles one 80-bit word per lane.
- Presents the words to core logic with a valid strobe.
- Sits between the s3/s4 LVDS rx megafunction wrapper and user logic.

Parameters:
SYNC_WORD, 80'hBC5A3C96F00FA55AC3E1, training word the transmitter repeats on all lanes during alignment.
CONFIRM_CNT, 4, number of consecutive boundary-aligned sync words (including the first hit) needed to declare alignment; legal range 1..15.

Ports:
I_clk  input  1  LVDS rx core clock; one beat per cycle.
I_rst  input  1  synchronous, active-high reset.
I_rx_locked  input  1  rx PLL lock from the LVDS core.
I_realign  input  1  single-cycle pulse; drop alignment and re-hunt.
I_rx_in  input  90  lane n occupies bits [10n+9:10n], n=0..8.
o0_p..o8_p  output  80 each  reassembled words, lanes 0..8.
O_valid  output  1  one-cycle strobe when o*_p update.
O_aligned  output  1  high in state LOCKED.
O_skew_err  output  1  sticky; sync seen on some but not all lanes in the same cycle.

Behaviour:
- Beat order: beat k of a word carries word bits [10k+9:10k]; beat 0 arrives first.
- Per-lane shift register, updated every cycle: sr <= {lane_beat, sr[79:10]}. After 8 beats, sr holds the word with beat 0 in bits [9:0].
- Shift registers run regardless of state.
- Phase counter ph: 3 bits, increments mod 8 every cycle.
- States:
  - IDLE: entered on reset, or whenever I_rx_locked=0 (this overrides all other conditions).
  - HUNT: if all 9 sr == SYNC_WORD this cycle, force ph to 0 next cycle, set cnt=1, go CONFIRM (or straight to LOCKED if CONFIRM_CNT=1). If 1..8 lanes match, set O_skew_err and stay in HUNT.
  - CONFIRM: evaluate only on ph==7. All lanes match: cnt++, and go to LOCKED when cnt reaches CONFIRM_CNT. Any mismatch: go to HUNT with cnt=0.
  - LOCKED: on each ph==7, capture every sr into its o*_p. O_valid=1 on the following cycle only, and o*_p update in that same cycle.
- Transitions:
  - IDLE -> HUNT when I_rx_locked=1.
  - I_realign=1 in any state other than IDLE -> HUNT, and clears O_skew_err. It takes priority over a same-cycle capture, so no O_valid is produced.
- Latency: last beat at cycle T (ph==7); data and O_valid appear at T+1.
- o*_p hold their value between strobes.
- Sync words received while LOCKED are delivered as ordinary data; there is no in-band re-framing.
- Reset values: o*_p=0, O_valid=0, O_aligned=0, O_skew_err=0, state=IDLE, ph=0, cnt=0, sr=0.
- An I_rx_locked drop while LOCKED deasserts O_aligned next cycle and suppresses any pending O_valid.

Decomposition:
- Shared package rx9_io80_pkg holds:
  - constants NUM_LANES=9, BEAT_W=10, BEATS=8, WORD_W=80;
  - default SYNC_WORD;
  - state typedef {IDLE, HUNT, CONFIRM, LOCKED}.
- Sub-module demux_10_80, instantiated 9 times. Each instance contains one lane's shift register, its SYNC_WORD compare output, and the 80-bit capture register with a capture enable.
- The top level holds the FSM, ph, cnt, skew detection and O_valid.

Test Plan:
1. Reset, I_rx_locked=1, all lanes send SYNC_WORD x4 then words 80'h0..01..80'h0..09 (lane n = n+1), repeated -> O_aligned rises one cycle after the 4th sync completes; then each lane outputs its value with O_valid one cycle after beat 7, every 8 cycles.
2. Inject the training sequence starting at an arbitrary beat offset 3 -> lock still achieved; first data word captured exactly on the word boundary.
3. Lane 5 delayed by one beat -> O_skew_err=1, O_aligned stays 0; then I_realign with lanes fixed -> O_skew_err clears, lock achieved.
4. Corrupt the 2nd sync word on lane 0 during CONFIRM -> return to HUNT; lock needs 4 fresh consecutive syncs.
5. I_rx_locked drops while LOCKED, on the same cycle as ph==7 -> no O_valid, O_aligned=0 next cycle, state IDLE; relock after I_rx_locked=1 plus the sync sequence.
6. Assert I_rst mid-CONFIRM and mid-LOCKED -> all outputs 0 the next cycle; assert I_realign on the ph==7 cycle -> no O_valid.
